fp32_div_seq: RTL and testbench

- Iterative IEEE 754 single-precision divider (y = a / b); the inverse-operation companion to the combinational fp32 multiplier in the ALU.
- Restoring mantissa division produces one quotient bit per clock; start/busy/done handshake.
- Truncating (round-toward-zero) rounding, matching the multiplier's rounding behaviour.
- Handles IEEE special cases and flushes denormals.

---
 rtl/fp32_pkg.sv | 92 +++++++++
 rtl/fp32_div_seq_step.sv | 22 ++
 rtl/fp32_div_seq.sv | 150 +++++++++++++++
 tb/tb_fp32_div_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32 divider shared types and constants.
// Operand classification and special-case result selection.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;
  localparam int EXT_W  = EXP_W + 2;
  localparam int CNT_W  = 5;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic signed [EXT_W-1:0] BIAS_E = EXT_W'(BIAS);
  localparam logic signed [EXT_W-1:0] ONE_E  = EXT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM
  } state_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fclass_t;

  typedef struct packed {
    logic dz;
    logic inv;
    logic ovf;
    logic unf;
  } flags_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] y;
    flags_t      f;
  } spec_t;

  // Denormals count as zero.
  function automatic fclass_t fp_class(input logic [31:0] x);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    e = x[MANT_W +: EXP_W];
    m = x[MANT_W-1:0];
    if (e == '0)
      return FP_ZERO;
    else if (&e)
      return (m != '0) ? FP_NAN : FP_INF;
    else
      return FP_NORMAL;
  endfunction

  // First matching special case wins.
  function automatic spec_t fp_special(
    input fclass_t ca,
    input fclass_t cb,
    input logic    s
  );
    spec_t r;
    logic [31:0] w_inf;
    logic [31:0] w_zero;
    w_inf  = {s, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    w_zero = {s, {(EXP_W + MANT_W){1'b0}}};
    r      = '0;
    r.hit  = 1'b1;
    if (ca == FP_NAN || cb == FP_NAN) begin
      r.y     = QNAN;
      r.f.inv = 1'b1;
    end else if ((ca == FP_ZERO && cb == FP_ZERO) ||
                 (ca == FP_INF && cb == FP_INF)) begin
      r.y     = QNAN;
      r.f.inv = 1'b1;
    end else if (ca == FP_INF) begin
      r.y = w_inf;
    end else if (cb == FP_INF) begin
      r.y = w_zero;
    end else if (cb == FP_ZERO) begin
      r.y    = w_inf;
      r.f.dz = 1'b1;
    end else if (ca == FP_ZERO) begin
      r.y = w_zero;
    end else begin
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp32_div_seq_step.sv
// One restoring division step on the mantissas.
// Kept separate so the loop can be unrolled later.
module fp_mant_div_step
  import fp32_pkg::*;
(
  input  logic [MANT_W+1:0] i_rem,
  input  logic [MANT_W:0]   i_d,
  output logic [MANT_W+1:0] o_rem_next,
  output logic              o_qbit
);

  logic [MANT_W+1:0] w_d_ext;
  logic [MANT_W+1:0] w_diff;

  assign w_d_ext = {1'b0, i_d};
  assign o_qbit  = (i_rem >= w_d_ext);
  assign w_diff  = i_rem - w_d_ext;

  assign o_rem_next = o_qbit ? {w_diff[MANT_W:0], 1'b0}
                             : {i_rem[MANT_W:0], 1'b0};

endmodule

// File: rtl/fp32_div_seq.sv
// Iterative fp32 divider, one quotient bit per clock.
// Truncating rounding, denormals flushed to zero.
module fp32_div_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        done,
  output logic        busy,
  output logic        div_by_zero,
  output logic        invalid,
  output logic        overflow,
  output logic        underflow
);

  state_t                   r_state;
  logic [MANT_W+1:0]        r_rem;
  logic [MANT_W:0]          r_d;
  logic [MANT_W+1:0]        r_q;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_sign;
  logic signed [EXT_W-1:0]  r_exp;
  spec_t                    r_spec;
  logic [31:0]              r_y;
  flags_t                   r_flags;
  logic                     r_done;
  logic                     r_busy;

  logic [MANT_W+1:0]        w_rem_next;
  logic                     w_qbit;
  logic                     w_sign;
  fclass_t                  w_cls_a;
  fclass_t                  w_cls_b;
  spec_t                    w_spec;
  logic signed [EXT_W-1:0]  w_ea;
  logic signed [EXT_W-1:0]  w_eb;
  logic signed [EXT_W-1:0]  w_exp_in;
  logic signed [EXT_W-1:0]  w_e;
  logic [MANT_W-1:0]        w_frac;
  logic                     w_ovf;
  logic                     w_unf;
  logic [31:0]              w_norm_y;
  flags_t                   w_norm_f;

  fp_mant_div_step u_step (
    .i_rem      (r_rem),
    .i_d        (r_d),
    .o_rem_next (w_rem_next),
    .o_qbit     (w_qbit)
  );

  assign w_sign   = a[31] ^ b[31];
  assign w_cls_a  = fp_class(a);
  assign w_cls_b  = fp_class(b);
  assign w_spec   = fp_special(w_cls_a, w_cls_b, w_sign);
  assign w_ea     = {2'b00, a[MANT_W +: EXP_W]};
  assign w_eb     = {2'b00, b[MANT_W +: EXP_W]};
  assign w_exp_in = w_ea - w_eb + BIAS_E;

  assign w_e    = r_q[MANT_W+1] ? r_exp : r_exp - ONE_E;
  assign w_frac = r_q[MANT_W+1] ? r_q[MANT_W:1] : r_q[MANT_W-1:0];

  assign w_ovf = !w_e[EXT_W-1] &&
                 (w_e[EXP_W] || (&w_e[EXP_W-1:0]));
  assign w_unf = w_e[EXT_W-1] || (w_e == '0);

  // Pack the normalised quotient, saturating the exponent.
  always_comb begin
    w_norm_f = '0;
    w_norm_y = {r_sign, w_e[EXP_W-1:0], w_frac};
    unique case (1'b1)
      w_ovf: begin
        w_norm_y   = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        w_norm_f.ovf = 1'b1;
      end
      w_unf: begin
        w_norm_y   = {r_sign, {(EXP_W + MANT_W){1'b0}}};
        w_norm_f.unf = 1'b1;
      end
      default: ;
    endcase
  end

  // Control FSM with registered result, flags and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_d     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_spec  <= '0;
      r_y     <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_sign <= w_sign;
            r_spec <= w_spec;
            r_exp  <= w_exp_in;
            r_busy <= 1'b1;
            if (w_spec.hit) begin
              r_state <= NORM;
            end else begin
              r_rem   <= {1'b0, 1'b1, a[MANT_W-1:0]};
              r_d     <= {1'b1, b[MANT_W-1:0]};
              r_q     <= '0;
              r_cnt   <= '0;
              r_state <= DIV;
            end
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[MANT_W:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST)
            r_state <= NORM;
        end
        NORM: begin
          r_y     <= r_spec.hit ? r_spec.y : w_norm_y;
          r_flags <= r_spec.hit ? r_spec.f : w_norm_f;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign y           = r_y;
  assign done        = r_done;
  assign busy        = r_busy;
  assign div_by_zero = r_flags.dz;
  assign invalid     = r_flags.inv;
  assign overflow    = r_flags.ovf;
  assign underflow   = r_flags.unf;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed bench for fp32_div_seq.
// Expected results are queued at launch and compared on done.
module tb_fp32_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] y;
  logic        done;
  logic        busy;
  logic        dz;
  logic        inv;
  logic        ovf;
  logic        unf;
  logic [3:0]  w_flags;
  logic        prev_done = 1'b0;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_DZ   = 4'b1000;
  localparam logic [3:0] F_INV  = 4'b0100;
  localparam logic [3:0] F_OVF  = 4'b0010;
  localparam logic [3:0] F_UNF  = 4'b0001;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  f;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e_q;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fp32_div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .y           (y),
    .done        (done),
    .busy        (busy),
    .div_by_zero (dz),
    .invalid     (inv),
    .overflow    (ovf),
    .underflow   (unf)
  );

  assign w_flags = {dz, inv, ovf, unf};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      if (done === 1'b1) begin
        chk("done_pulse", 64'(prev_done), 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e_q = sb.pop_front();
          chk({e_q.tag, "_y"}, 64'(y), 64'(e_q.y));
          chk({e_q.tag, "_flags"}, 64'(w_flags), 64'(e_q.f));
        end
      end
      prev_done <= done;
    end
  end

  task automatic launch(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ey, input logic [3:0] ef,
                        input string tag, input bit push);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    if (push) sb.push_back('{ey, ef, tag});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    bit ok;
    ok = 1'b1;
    n = 0;
    if (busy !== 1'b1) ok = 1'b0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) ok = 1'b0;
    end
    chk({tag, "_busy_high"}, 64'(ok), 64'd1);
    chk({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ey, input logic [3:0] ef,
                        input int lat, input string tag);
    int n;
    launch(ia, ib, ey, ef, tag, 1'b1);
    wait_done(tag, n);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
  endtask

  initial begin
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 64'({y, done, busy, w_flags}), 64'd0);
    rst_n = 1'b1;

    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 26, "six_div_two");
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, F_NONE, 26, "one_div_three");
    run_op(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, F_NONE, 26, "neg_six_div_two");
    run_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, F_DZ, 1, "neg_one_div_zero");
    run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, F_INV, 1, "zero_div_zero");
    run_op(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, F_INV, 1, "inf_div_inf");
    run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, F_INV, 1, "nan_div_one");
    run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, F_NONE, 1, "neg_inf_div_two");
    run_op(32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, F_NONE, 1, "one_div_neg_inf");
    run_op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, F_NONE, 1, "denorm_div_one");
    run_op(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, F_OVF, 26, "overflow");
    run_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, F_UNF, 26, "underflow");

    // start during DIV must be ignored
    launch(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, "ignore_first", 1'b1);
    repeat (5) @(posedge clk);
    #1;
    a = 32'h3F80_0000;
    b = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignore_first", n);
    chk("ignore_first_lat", 64'(n), 64'd20);
    repeat (30) @(posedge clk);
    #1;
    chk("ignore_no_extra", 64'(sb.size()), 64'd0);

    // start in the done cycle is accepted
    launch(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, F_NONE, "done_cycle_a", 1'b1);
    wait_done("done_cycle_a", n);
    chk("done_cycle_a_lat", 64'(n), 64'd26);
    a = 32'h40C0_0000;
    b = 32'h4000_0000;
    start = 1'b1;
    sb.push_back('{32'h4040_0000, F_NONE, "done_cycle_b"});
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("done_cycle_b", n);
    chk("done_cycle_b_lat", 64'(n), 64'd26);

    // reset at iteration 10 aborts the operation
    launch(32'h3F80_0000, 32'h4040_0000, 32'h0, F_NONE, "aborted", 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_out", 64'({y, done, busy, w_flags}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("after_abort_idle", 64'({y, done, busy, w_flags}), 64'd0);
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 26, "after_reset");

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
